// File: rtl/sd_tx_pkg.sv
// Shared types and constants for the SD DAT-line block transmitter.
package sd_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREP,
        ST_DATA,
        ST_CRC,
        ST_END,
        ST_RELEASE
    } tx_state_t;

    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam logic [15:0] CRC16_INIT = 16'h0000;
    localparam logic        START_BIT  = 1'b0;
    localparam logic        END_BIT    = 1'b1;

    function automatic logic [15:0] crc16_next(
        input logic [15:0] crc,
        input logic        b
    );
        crc16_next = {crc[14:0], 1'b0} ^ ((b ^ crc[15]) ? CRC16_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/sd_crc16_serial.sv
// Bit-serial CRC16-CCITT: accumulates data bits, then shifts the
// remainder out MSB-first through o_msb.
module sd_crc16_serial
    import sd_tx_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_upd,
    input  logic i_bit,
    input  logic i_shift,
    output logic o_msb
);

    logic [15:0] r_crc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_crc <= CRC16_INIT;
        end else if (i_clr) begin
            r_crc <= CRC16_INIT;
        end else if (i_upd) begin
            r_crc <= crc16_next(r_crc, i_bit);
        end else if (i_shift) begin
            r_crc <= {r_crc[14:0], 1'b0};
        end
    end

    assign o_msb = r_crc[15];

endmodule

// File: rtl/sd_dat_tx.sv
// Serialises one SD data block (start bit, data, CRC16, end bit) onto
// a single DAT line, paced by the shared SD bit strobe.
module sd_dat_tx
    import sd_tx_pkg::*;
#(
    parameter  int BLOCK_BYTES = 512,
    localparam int CNT_W       = $clog2(BLOCK_BYTES + 1)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       shift_enable_sd,
    input  logic       start,
    input  logic [7:0] byte_data,
    input  logic       byte_valid,
    output logic       byte_ready,
    output logic       dat_out,
    output logic       dat_oe,
    output logic       busy,
    output logic       done,
    output logic       underrun
);

    localparam logic [CNT_W-1:0] W_LAST = CNT_W'(BLOCK_BYTES);

    tx_state_t        r_state;
    logic [7:0]       r_hold;
    logic             r_hold_full;
    logic [7:0]       r_shift;
    logic [3:0]       r_bits;
    logic [CNT_W-1:0] r_accepted;
    logic [3:0]       r_crc_cnt;
    logic             r_dat_out;
    logic             r_dat_oe;
    logic             r_done;
    logic             r_underrun;

    logic w_ready;
    logic w_take;
    logic w_emit;
    logic w_starve;
    logic w_shift_free;
    logic w_last_bit;
    logic w_crc_msb;

    assign w_ready = (r_state == ST_PREP || r_state == ST_DATA)
                   && !r_hold_full && (r_accepted < W_LAST);
    assign w_take   = byte_valid && w_ready;
    assign w_emit   = shift_enable_sd && r_state == ST_DATA && r_bits != 4'd0;
    assign w_starve = shift_enable_sd && r_state == ST_DATA && r_bits == 4'd0;
    assign w_shift_free = (r_bits == 4'd0) || (w_emit && r_bits == 4'd1);
    assign w_last_bit = w_emit && r_bits == 4'd1 && !r_hold_full
                      && r_accepted == W_LAST;

    sd_crc16_serial u_crc (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (r_state == ST_IDLE && start),
        .i_upd   (w_emit),
        .i_bit   (r_shift[7]),
        .i_shift (shift_enable_sd && r_state == ST_CRC),
        .o_msb   (w_crc_msb)
    );

    // An empty shift register takes the hold byte, or the incoming byte
    // directly, so a tick every clock never starves the line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_shift     <= '0;
            r_bits      <= '0;
            r_accepted  <= '0;
        end else if (r_state == ST_IDLE || w_starve) begin
            r_hold_full <= 1'b0;
            r_bits      <= '0;
            if (r_state == ST_IDLE && start) begin
                r_accepted <= '0;
            end
        end else begin
            if (w_take) begin
                r_accepted <= r_accepted + CNT_W'(1);
            end
            if (w_shift_free && r_hold_full) begin
                r_shift     <= r_hold;
                r_bits      <= 4'd8;
                r_hold_full <= 1'b0;
            end else if (w_shift_free && w_take) begin
                r_shift <= byte_data;
                r_bits  <= 4'd8;
            end else begin
                if (w_emit) begin
                    r_shift <= {r_shift[6:0], 1'b0};
                    r_bits  <= r_bits - 4'd1;
                end
                if (w_take) begin
                    r_hold      <= byte_data;
                    r_hold_full <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_dat_out  <= 1'b1;
            r_dat_oe   <= 1'b0;
            r_done     <= 1'b0;
            r_underrun <= 1'b0;
            r_crc_cnt  <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state    <= ST_PREP;
                        r_underrun <= 1'b0;
                    end
                end
                ST_PREP: begin
                    if (shift_enable_sd) begin
                        r_dat_out <= START_BIT;
                        r_dat_oe  <= 1'b1;
                        r_state   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_starve) begin
                        r_dat_out  <= 1'b1;
                        r_dat_oe   <= 1'b0;
                        r_underrun <= 1'b1;
                        r_state    <= ST_IDLE;
                    end else if (w_emit) begin
                        r_dat_out <= r_shift[7];
                        if (w_last_bit) begin
                            r_state   <= ST_CRC;
                            r_crc_cnt <= '0;
                        end
                    end
                end
                ST_CRC: begin
                    if (shift_enable_sd) begin
                        r_dat_out <= w_crc_msb;
                        r_crc_cnt <= r_crc_cnt + 4'd1;
                        if (r_crc_cnt == 4'd15) begin
                            r_state <= ST_END;
                        end
                    end
                end
                ST_END: begin
                    if (shift_enable_sd) begin
                        r_dat_out <= END_BIT;
                        r_state   <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (shift_enable_sd) begin
                        r_dat_oe  <= 1'b0;
                        r_dat_out <= 1'b1;
                        r_done    <= 1'b1;
                        r_state   <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign byte_ready = w_ready;
    assign dat_out    = r_dat_out;
    assign dat_oe     = r_dat_oe;
    assign busy       = (r_state != ST_IDLE);
    assign done       = r_done;
    assign underrun   = r_underrun;

endmodule

// File: tb/tb_sd_dat_tx.sv
// Bench for sd_dat_tx: three block sizes (9, 4, 512) checked against a
// byte-wise CRC16 reference and expected DAT bit streams.
module tb_sd_dat_tx;

    localparam int NI   = 3;
    localparam int RECN = 4200;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tick = 1'b0;
    logic [NI-1:0] st = '0;
    logic [NI-1:0] bv = '0;
    logic [NI-1:0] rdy, dout, oe, bz, dn, ur;
    logic [7:0]    bd [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        sd_dat_tx #(
            .BLOCK_BYTES(g == 0 ? 9 : (g == 1 ? 4 : 512))
        ) u_dut (
            .clk             (clk),
            .rst             (rst),
            .shift_enable_sd (tick),
            .start           (st[g]),
            .byte_data       (bd[g]),
            .byte_valid      (bv[g]),
            .byte_ready      (rdy[g]),
            .dat_out         (dout[g]),
            .dat_oe          (oe[g]),
            .busy            (bz[g]),
            .done            (dn[g]),
            .underrun        (ur[g])
        );
    end

    int checks = 0;
    int errors = 0;
    int tick_div = 0;
    int tcnt = 0;
    logic [7:0] mem [NI][0:511];
    int nend [NI];
    int ptr  [NI];
    int rn   [NI];
    int bt   [NI];
    int dcnt [NI];
    logic rec [NI][0:RECN-1];
    logic expb [0:RECN-1];
    logic [15:0] exp_crc;
    logic [15:0] last_crc;
    logic [NI-1:0] hs = '0;
    logic [NI-1:0] bz_s = '0;
    logic tk_s = 1'b0;

    always @(posedge clk) begin
        hs   <= bv & rdy;
        bz_s <= bz;
        tk_s <= tick;
    end

    // Byte feeder, DAT recorder and tick generator.
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (hs[i]) ptr[i] = ptr[i] + 1;
            if (tk_s && oe[i] && rn[i] < RECN) begin
                rec[i][rn[i]] = dout[i];
                rn[i] = rn[i] + 1;
            end
            if (tk_s && bz_s[i]) bt[i] = bt[i] + 1;
            if (dn[i]) dcnt[i] = dcnt[i] + 1;
            bv[i] = (ptr[i] < nend[i]);
            bd[i] = mem[i][ptr[i] % 512];
        end
        if (tick_div == 0) begin
            tick = 1'b0;
        end else begin
            tcnt = tcnt + 1;
            tick = (tcnt % tick_div == 0);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_start(input int i);
        st[i] = 1'b1;
        step();
        st[i] = 1'b0;
    endtask

    // Reference: start bit, bytes MSB-first, byte-wise CRC16, end bit.
    function automatic int build(input int i, input int base, input int n);
        logic [15:0] c;
        logic [7:0]  b;
        int k;
        c = 16'h0000;
        k = 0;
        expb[k] = 1'b0; k++;
        for (int m = 0; m < n; m++) begin
            b = mem[i][(base + m) % 512];
            for (int j = 7; j >= 0; j--) begin
                expb[k] = b[j]; k++;
            end
            c = c ^ {b, 8'h00};
            for (int j = 0; j < 8; j++)
                c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
        end
        for (int j = 15; j >= 0; j--) begin
            expb[k] = c[j]; k++;
        end
        expb[k] = 1'b1; k++;
        exp_crc = c;
        return k;
    endfunction

    task automatic cmp_block(input int i, input int rb, input int base,
                             input int n, input string tag);
        int len, bad;
        logic [15:0] got;
        len = build(i, base, n);
        chk({tag, "_len"}, rn[i] - rb, len);
        bad = 0;
        for (int k = 0; k < len; k++)
            if (rb + k >= RECN || rec[i][rb + k] !== expb[k]) bad++;
        chk({tag, "_bits"}, bad, 0);
        got = '0;
        for (int j = 0; j < 16; j++)
            if (rb + 1 + 8 * n + j < RECN)
                got = {got[14:0], rec[i][rb + 1 + 8 * n + j]};
        last_crc = got;
    endtask

    task automatic wait_rec(input int i, input int target, input int lim,
                            input string tag);
        int c = 0;
        while (rn[i] < target && c < lim) begin step(); c++; end
        chk(tag, 32'(rn[i] >= target), 32'h1);
    endtask

    task automatic wait_done(input int i, input int d0, input int lim,
                             input string tag);
        int c = 0;
        while (dcnt[i] == d0 && c < lim) begin step(); c++; end
        chk(tag, 32'(dcnt[i] != d0), 32'h1);
    endtask

    task automatic wait_ur(input int i, input int lim, input string tag);
        int c = 0;
        while (ur[i] !== 1'b1 && c < lim) begin step(); c++; end
        chk(tag, 32'(ur[i]), 32'h1);
    endtask

    initial begin
        string s;
        int rb, d0, b0, bad, len, base;
        logic s_dout, s_oe, s_bz;
        int s_rn;

        repeat (3) step();
        chk("rst_dout", 32'(dout), 32'h7);
        chk("rst_oe",   32'(oe),   32'h0);
        chk("rst_busy", 32'(bz),   32'h0);
        chk("rst_done", 32'(dn),   32'h0);
        chk("rst_ur",   32'(ur),   32'h0);
        rst = 1'b0;
        step();
        chk("idle_ready", 32'(rdy), 32'h0);

        // A: "123456789", tick every clock, extra starts in DATA/RELEASE
        s = "123456789";
        for (int m = 0; m < 9; m++) mem[0][m] = s[m];
        nend[0] = 9;
        tick_div = 1;
        step();
        rb = rn[0]; d0 = dcnt[0]; b0 = bt[0];
        pulse_start(0);
        chk("A_busy", 32'(bz[0]), 32'h1);
        wait_rec(0, rb + 40, 200, "A_mid_wait");
        pulse_start(0);
        wait_rec(0, rb + 90, 200, "A_end_wait");
        pulse_start(0);
        repeat (6) step();
        chk("A_done_cnt", dcnt[0] - d0, 1);
        chk("A_busy_ticks", bt[0] - b0, 91);
        chk("A_idle", 32'(bz[0]), 32'h0);
        chk("A_oe_rel", 32'(oe[0]), 32'h0);
        chk("A_ur", 32'(ur[0]), 32'h0);
        cmp_block(0, rb, 0, 9, "A");
        chk("A_crc", 32'(last_crc), 32'h31C3);

        // B: 4-byte block starved after two bytes
        for (int m = 0; m < 4; m++) mem[1][m] = 8'($urandom);
        nend[1] = 2;
        rb = rn[1]; d0 = dcnt[1]; b0 = bt[1];
        pulse_start(1);
        wait_ur(1, 200, "B_ur");
        chk("B_oe", 32'(oe[1]), 32'h0);
        chk("B_dout", 32'(dout[1]), 32'h1);
        chk("B_busy", 32'(bz[1]), 32'h0);
        chk("B_tick", bt[1] - b0, 18);
        chk("B_len", rn[1] - rb, 17);
        len = build(1, 0, 4);
        bad = 0;
        for (int k = 0; k < 17; k++)
            if (rec[1][rb + k] !== expb[k]) bad++;
        chk("B_prefix", bad, 0);
        repeat (3) step();
        chk("B_sticky", 32'(ur[1]), 32'h1);
        chk("B_nodone", dcnt[1] - d0, 0);
        base = ptr[1];
        for (int m = 0; m < 4; m++) mem[1][base + m] = 8'($urandom);
        nend[1] = base + 4;
        rb = rn[1]; d0 = dcnt[1];
        pulse_start(1);
        chk("B_ur_clr", 32'(ur[1]), 32'h0);
        wait_done(1, d0, 300, "B2_done");
        cmp_block(1, rb, base, 4, "B2");
        chk("B2_ur", 32'(ur[1]), 32'h0);

        // C: reset in the CRC phase, then an all-zero block
        base = ptr[0];
        for (int m = 0; m < 9; m++) mem[0][base + m] = 8'($urandom);
        nend[0] = base + 9;
        rb = rn[0]; d0 = dcnt[0];
        pulse_start(0);
        wait_rec(0, rb + 78, 300, "C_crc_wait");
        rst = 1'b1;
        step();
        chk("C_rst_oe", 32'(oe[0]), 32'h0);
        chk("C_rst_dout", 32'(dout[0]), 32'h1);
        chk("C_rst_busy", 32'(bz[0]), 32'h0);
        chk("C_rst_ur", 32'(ur[0]), 32'h0);
        chk("C_rst_nodone", dcnt[0] - d0, 0);
        rst = 1'b0;
        step();
        base = ptr[0];
        for (int m = 0; m < 9; m++) mem[0][base + m] = 8'h00;
        nend[0] = base + 9;
        rb = rn[0]; d0 = dcnt[0];
        pulse_start(0);
        wait_done(0, d0, 300, "C_done");
        cmp_block(0, rb, base, 9, "C");
        chk("C_crc", 32'(last_crc), 32'h0000);

        // D: 512 x 0xFF, tick every 4 clocks, 100-clock tick freeze
        for (int m = 0; m < 512; m++) mem[2][m] = 8'hFF;
        nend[2] = 512;
        tick_div = 4;
        step();
        rb = rn[2]; d0 = dcnt[2]; b0 = bt[2];
        pulse_start(2);
        wait_rec(2, rb + 200, 2000, "D_mid_wait");
        tick_div = 0;
        repeat (2) step();
        s_dout = dout[2]; s_oe = oe[2]; s_bz = bz[2]; s_rn = rn[2];
        repeat (100) step();
        chk("D_frz_dout", 32'(dout[2]), 32'(s_dout));
        chk("D_frz_oe", 32'(oe[2]), 32'h1);
        chk("D_frz_busy", 32'(bz[2]), 32'(s_bz));
        chk("D_frz_rec", rn[2], s_rn);
        chk("D_frz_oe_snap", 32'(s_oe), 32'(oe[2]));
        tick_div = 4;
        wait_done(2, d0, 20000, "D_done");
        cmp_block(2, rb, 0, 512, "D");
        chk("D_crc", 32'(last_crc), 32'h7FA1);
        chk("D_ticks", bt[2] - b0, 4115);
        chk("D_ur", 32'(ur[2]), 32'h0);
        step();
        chk("D_oe_rel", 32'(oe[2]), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
